// File: rtl/naneye_cfg_sequencer.sv
// NanEye configuration write sequencer: takes one word from the register bank,
// waits for the sensor's end of frame, then shifts it out MSB-first over the
// shared single-wire link during the inter-frame gap.
module naneye_cfg_sequencer #(
    parameter int unsigned CFG_BITS    = 16,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned START_DELAY = 8,
    parameter int unsigned TURN_CYCLES = 4
) (
    input  logic                SYS_CLOCK,
    input  logic                RESET,
    input  logic                FRAME_END,
    input  logic                CFG_REQ,
    input  logic [CFG_BITS-1:0] CFG_DATA,
    output logic                CFG_ACK,
    output logic                CFG_BUSY,
    output logic                CFG_DONE,
    output logic                TX_OE_N,
    output logic                TX_DAT,
    output logic                TX_CLK
);

    localparam int unsigned BIT_W    = $clog2(CFG_BITS + 1);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV + 1);
    localparam int unsigned WAIT_MAX = (START_DELAY > TURN_CYCLES) ? START_DELAY : TURN_CYCLES;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(CFG_BITS - 1);
    localparam logic [DIV_W-1:0]  DIV_LOAD   = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] DELAY_LOAD = WAIT_W'(START_DELAY - 1);
    localparam logic [WAIT_W-1:0] GUARD_LOAD = WAIT_W'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_SHIFT,
        S_TAIL,
        S_GUARD
    } state_e;

    state_e              state_q,  state_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [BIT_W-1:0]    bit_q,    bit_d;
    logic [DIV_W-1:0]    div_q,    div_d;
    logic [WAIT_W-1:0]   wait_q,   wait_d;
    logic                ack_q,    ack_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                oe_n_q,   oe_n_d;
    logic                dat_q,    dat_d;
    logic                tck_q,    tck_d;

    // State register and registered outputs; reset releases the line at once.
    always_ff @(posedge SYS_CLOCK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            wait_q   <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            oe_n_q   <= 1'b1;
            dat_q    <= 1'b0;
            tck_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            wait_q   <= wait_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            oe_n_q   <= oe_n_d;
            dat_q    <= dat_d;
            tck_q    <= tck_d;
        end
    end

    // Next-state and next-output logic; shadow shifts left so its MSB is the next bit.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bit_d    = bit_q;
        div_d    = div_q;
        wait_d   = wait_q;
        ack_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        oe_n_d   = oe_n_q;
        dat_d    = dat_q;
        tck_d    = tck_q;

        // BUSY drops the cycle after DONE unless a new request is taken on that edge.
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (CFG_REQ) begin
                    shadow_d = CFG_DATA;
                    ack_d    = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = S_ARMED;
                end
            end
            S_ARMED: begin
                if (FRAME_END) begin
                    wait_d  = DELAY_LOAD;
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (wait_q == '0) begin
                    oe_n_d   = 1'b0;
                    dat_d    = shadow_q[CFG_BITS-1];
                    shadow_d = {shadow_q[CFG_BITS-2:0], 1'b0};
                    bit_d    = BIT_LAST;
                    div_d    = DIV_LOAD;
                    tck_d    = 1'b0;
                    state_d  = S_SHIFT;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else begin
                    div_d = DIV_LOAD;
                    if (!tck_q) begin
                        tck_d = 1'b1;
                    end else begin
                        tck_d = 1'b0;
                        if (bit_q == '0) begin
                            state_d = S_TAIL;
                        end else begin
                            dat_d    = shadow_q[CFG_BITS-1];
                            shadow_d = {shadow_q[CFG_BITS-2:0], 1'b0};
                            bit_d    = bit_q - BIT_W'(1);
                        end
                    end
                end
            end
            S_TAIL: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else begin
                    oe_n_d  = 1'b1;
                    dat_d   = 1'b0;
                    wait_d  = GUARD_LOAD;
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                if (wait_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign CFG_ACK  = ack_q;
    assign CFG_BUSY = busy_q;
    assign CFG_DONE = done_q;
    assign TX_OE_N  = oe_n_q;
    assign TX_DAT   = dat_q;
    assign TX_CLK   = tck_q;

endmodule

// File: tb/tb_naneye_cfg_sequencer.sv
// Bench for naneye_cfg_sequencer: a default-parameter instance and a minimal
// instance (2 bits, divide-by-1) checked every cycle against a timeline model,
// plus literal timeline expectations per transfer.
module tb_naneye_cfg_sequencer;

    localparam int B0 = 16, CD0 = 4, SD0 = 8, T0 = 4;
    localparam int B1 = 2,  CD1 = 1, SD1 = 1, T1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, req, fe;
    logic [15:0] data0;
    logic [1:0]  data1;
    logic [1:0]  ack, busy, done, oe_n, dat, tck;

    naneye_cfg_sequencer #(.CFG_BITS(B0), .CLK_DIV(CD0), .START_DELAY(SD0), .TURN_CYCLES(T0)) u_dut (
        .SYS_CLOCK(clk), .RESET(rst[0]), .FRAME_END(fe[0]), .CFG_REQ(req[0]), .CFG_DATA(data0),
        .CFG_ACK(ack[0]), .CFG_BUSY(busy[0]), .CFG_DONE(done[0]),
        .TX_OE_N(oe_n[0]), .TX_DAT(dat[0]), .TX_CLK(tck[0])
    );

    naneye_cfg_sequencer #(.CFG_BITS(B1), .CLK_DIV(CD1), .START_DELAY(SD1), .TURN_CYCLES(T1)) u_small (
        .SYS_CLOCK(clk), .RESET(rst[1]), .FRAME_END(fe[1]), .CFG_REQ(req[1]), .CFG_DATA(data1),
        .CFG_ACK(ack[1]), .CFG_BUSY(busy[1]), .CFG_DONE(done[1]),
        .TX_OE_N(oe_n[1]), .TX_DAT(dat[1]), .TX_CLK(tck[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Edge counter and the inputs as the DUTs saw them at the last rising edge.
    int          t = 0;
    logic [1:0]  s_rst = 2'b11, s_req = 2'b00, s_fe = 2'b00;
    logic [15:0] s_data [2];
    always @(posedge clk) begin
        t         <= t + 1;
        s_rst     <= rst;
        s_req     <= req;
        s_fe      <= fe;
        s_data[0] <= data0;
        s_data[1] <= {14'd0, data1};
    end

    // Timeline model state per instance.
    bit          m_have [2];
    bit          m_trig [2];
    bit          started[2];
    int          m_k    [2];
    logic [15:0] m_word [2];

    function automatic void check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (t=%0d)", name, got, exp, t);
        end
    endfunction

    // Derive expected outputs after edge t from when ACK and FRAME_END happened.
    task automatic model_cycle();
        int b, cd, sd, tc, o, win;
        logic ea, ed, eoe, edat, etck;
        logic [5:0] e, g;
        for (int i = 0; i < 2; i++) begin
            b  = (i == 0) ? B0  : B1;
            cd = (i == 0) ? CD0 : CD1;
            sd = (i == 0) ? SD0 : SD1;
            tc = (i == 0) ? T0  : T1;
            win = (2 * b + 1) * cd;
            if (s_rst[i]) begin
                m_have[i]  = 1'b0;
                m_trig[i]  = 1'b0;
                started[i] = 1'b1;
                e = 6'b000100;
            end else begin
                ea = 1'b0;
                ed = 1'b0;
                if (!m_have[i] && s_req[i]) begin
                    m_have[i] = 1'b1;
                    m_trig[i] = 1'b0;
                    m_word[i] = s_data[i];
                    ea = 1'b1;
                end else if (m_have[i] && !m_trig[i] && s_fe[i]) begin
                    m_trig[i] = 1'b1;
                    m_k[i]    = t;
                end
                if (m_have[i] && m_trig[i] && t == m_k[i] + sd + win + tc) begin
                    ed = 1'b1;
                    m_have[i] = 1'b0;
                end
                eoe = 1'b1; etck = 1'b0; edat = 1'b0;
                if (m_trig[i]) begin
                    o = t - (m_k[i] + sd);
                    if (o >= 0 && o < win) begin
                        eoe = 1'b0;
                        if (o < 2 * b * cd) begin
                            etck = ((o / cd) % 2) == 1;
                            edat = m_word[i][b - 1 - o / (2 * cd)];
                        end else begin
                            edat = m_word[i][0];
                        end
                    end
                end
                e = {ea, ea | m_have[i] | ed, ed, eoe, edat, etck};
            end
            if (started[i]) begin
                g = {ack[i], busy[i], done[i], oe_n[i], dat[i], tck[i]};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL cycle inst=%0d t=%0d got=%b expected=%b {ack,busy,done,oe_n,dat,tck}",
                             i, t, g, e);
                end
            end
        end
    endtask

    // Every bench wait goes through here so the model sees every cycle.
    task automatic step();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic request(input int i, input logic [15:0] w, input int budget);
        bit ok;
        ok = 1'b0;
        if (i == 0) data0 = w; else data1 = w[1:0];
        req[i] = 1'b1;
        for (int c = 0; c < budget; c++) begin
            step();
            if (ack[i]) begin ok = 1'b1; break; end
        end
        check("ack_seen", int'(ok), 1);
        req[i] = 1'b0;
        step();
        check("ack_one_cycle", int'(ack[i]), 0);
    endtask

    // Pulse FRAME_END and measure the transfer relative to its sampling edge.
    task automatic fire(input int i, input logic [15:0] exp_word, input int exp_lo,
                        input int exp_hi, input int exp_dn, input int exp_rises, input int extra_fe);
        int k, rel, lo, hi, dn, rises, acks;
        logic [15:0] bits;
        logic p_oe, p_tck;
        lo = -1; hi = -1; dn = -1; rises = 0; acks = 0; bits = '0;
        fe[i] = 1'b1;
        step();
        k = t;
        fe[i] = 1'b0;
        p_oe = oe_n[i];
        p_tck = tck[i];
        for (int c = 0; c < 400; c++) begin
            step();
            rel = t - k;
            fe[i] = (rel == extra_fe);
            if (p_oe && !oe_n[i]) lo = rel;
            if (!p_oe && oe_n[i]) hi = rel;
            if (!p_tck && tck[i]) begin
                rises++;
                bits = {bits[14:0], dat[i]};
            end
            if (ack[i]) acks++;
            p_oe = oe_n[i];
            p_tck = tck[i];
            if (done[i]) begin dn = rel; break; end
        end
        fe[i] = 1'b0;
        check("oe_low_at", lo, exp_lo);
        check("oe_high_at", hi, exp_hi);
        check("done_at", dn, exp_dn);
        check("clk_rises", rises, exp_rises);
        check("word_sent", int'(bits), int'(exp_word));
        check("no_ack_in_flight", acks, 0);
    endtask

    initial begin
        int bad, rises;
        rst = 2'b11; req = 2'b00; fe = 2'b00; data0 = '0; data1 = '0;
        idle(2);
        rst = 2'b00;
        check("reset_outputs", int'({ack[0], busy[0], done[0], oe_n[0], dat[0], tck[0]}), 6'b000100);
        idle(3);

        // Basic transfer, FRAME_END 20 cycles after the request.
        request(0, 16'hA5C3, 5);
        idle(19);
        fire(0, 16'hA5C3, 8, 140, 144, 16, -1);
        idle(3);
        check("busy_cleared", int'(busy[0]), 0);

        // Armed indefinitely: line untouched until FRAME_END.
        request(0, 16'h3C96, 5);
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (!(busy[0] && oe_n[0] && !tck[0])) bad++;
        end
        check("armed_hold", bad, 0);
        fire(0, 16'h3C96, 8, 140, 144, 16, -1);
        idle(3);

        // FRAME_END in IDLE does nothing; a second pulse during SHIFT does not retrigger.
        fe[0] = 1'b1;
        step();
        fe[0] = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (busy[0] || !oe_n[0]) bad++;
        end
        check("idle_frame_end", bad, 0);
        request(0, 16'hC3A5, 5);
        idle(4);
        fire(0, 16'hC3A5, 8, 140, 144, 16, 40);
        idle(200);
        check("no_retrigger", int'({busy[0], oe_n[0]}), 2'b01);

        // Back-to-back: second request held through the first transfer.
        request(0, 16'h8001, 5);
        data0 = 16'h0F0F;
        req[0] = 1'b1;
        idle(6);
        fire(0, 16'h8001, 8, 140, 144, 16, -1);
        step();
        check("ack_after_done", int'(ack[0]), 1);
        req[0] = 1'b0;
        data0 = 16'hFFFF;
        idle(10);
        fire(0, 16'h0F0F, 8, 140, 144, 16, -1);
        idle(3);

        // Reset at the 5th TX_CLK rise.
        request(0, 16'h1234, 5);
        idle(2);
        fe[0] = 1'b1;
        step();
        fe[0] = 1'b0;
        rises = 0;
        for (int c = 0; c < 200 && rises < 5; c++) begin
            step();
            if (tck[0]) rises++;
            while (tck[0] && rises < 5) step();
        end
        check("fifth_rise", rises, 5);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check("reset_mid", int'({busy[0], done[0], oe_n[0], tck[0]}), 4'b0010);
        bad = 0;
        for (int c = 0; c < 150; c++) begin
            step();
            if (done[0] || !oe_n[0]) bad++;
        end
        check("no_done_after_reset", bad, 0);
        request(0, 16'h5A5A, 3);
        idle(5);
        fire(0, 16'h5A5A, 8, 140, 144, 16, -1);
        idle(3);

        // Minimal configuration instance.
        request(1, 16'h0002, 3);
        idle(4);
        fire(1, 16'h0002, 1, 6, 7, 2, -1);
        idle(2);
        request(1, 16'h0001, 3);
        idle(2);
        fire(1, 16'h0001, 1, 6, 7, 2, -1);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0d", t);
        $fatal(1, "watchdog");
    end

endmodule
